// File: rtl/channel_send.sv
// Executes one OUT (send) on a rendezvous channel held in shared RAM.
// Handles three cases: empty channel, plain receiver waiting, and ALT receiver enabled.
module channel_send #(
  parameter int addrBits = 8,
  parameter int dataBits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enabled,
  output logic                finished,
  output logic [addrBits-1:0] address,
  output logic                readWriteMode,
  input  logic [dataBits-1:0] dataOut,
  output logic [dataBits-1:0] dataIn,
  input  logic [addrBits-1:0] channel,
  input  logic [addrBits-1:0] txPid,
  input  logic [dataBits-1:0] message,
  output logic                shouldScheduleReceiver,
  output logic [addrBits-1:0] scheduleRxPid,
  output logic                hasDeliveredMessage,
  output logic [dataBits-1:0] deliveredMessage,
  output logic                shouldDescheduleSender,
  output logic                protocolError
);

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  typedef enum logic [2:0] {INIT, CAPTURE, DECIDE, WRITE_MSG, DONE} state_t;

  state_t              state, nextState;
  logic [dataBits-1:0] rWord;
  logic [dataBits-1:0] txWord;
  logic                setFinished, setSched, setDeliv, setDesched, setError;

  // Sender word: TX flag plus pid; the receiver's disable phase only looks at the pid bits.
  always_comb begin
    txWord                 = '0;
    txWord[dataBits-2]     = 1'b1;
    txWord[addrBits-1:0]   = txPid;
  end

  always_comb begin
    nextState     = state;
    readWriteMode = RAM_READ;
    address       = channel;
    dataIn        = '0;
    setFinished   = 1'b0;
    setSched      = 1'b0;
    setDeliv      = 1'b0;
    setDesched    = 1'b0;
    setError      = 1'b0;
    case (state)
      INIT:    nextState = CAPTURE;
      CAPTURE: nextState = DECIDE;
      DECIDE: begin
        if (rWord[dataBits-2]) begin
          setError    = 1'b1;
          setFinished = 1'b1;
          nextState   = DONE;
        end else if (rWord == '0 || rWord[dataBits-1]) begin
          readWriteMode = RAM_WRITE;
          dataIn        = txWord;
          setSched      = rWord[dataBits-1];
          nextState     = WRITE_MSG;
        end else begin
          readWriteMode = RAM_WRITE;
          dataIn        = '0;
          setSched      = 1'b1;
          setDeliv      = 1'b1;
          setFinished   = 1'b1;
          nextState     = DONE;
        end
      end
      WRITE_MSG: begin
        address       = channel + addrBits'(1);
        readWriteMode = RAM_WRITE;
        dataIn        = message;
        setDesched    = 1'b1;
        setFinished   = 1'b1;
        nextState     = DONE;
      end
      DONE:    nextState = DONE;
      default: nextState = INIT;
    endcase
    // An abort must not let the in-flight write reach RAM.
    if (reset || !enabled) begin
      readWriteMode = RAM_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= INIT;
      rWord                  <= '0;
      finished               <= 1'b0;
      shouldScheduleReceiver <= 1'b0;
      scheduleRxPid          <= '0;
      hasDeliveredMessage    <= 1'b0;
      deliveredMessage       <= '0;
      shouldDescheduleSender <= 1'b0;
      protocolError          <= 1'b0;
    end else if (!enabled) begin
      state                  <= INIT;
      finished               <= 1'b0;
      shouldScheduleReceiver <= 1'b0;
      hasDeliveredMessage    <= 1'b0;
      shouldDescheduleSender <= 1'b0;
      protocolError          <= 1'b0;
    end else begin
      state <= nextState;
      if (state == CAPTURE) rWord <= dataOut;
      if (setFinished) finished <= 1'b1;
      if (setSched) begin
        shouldScheduleReceiver <= 1'b1;
        scheduleRxPid          <= rWord[addrBits-1:0];
      end
      if (setDeliv) begin
        hasDeliveredMessage <= 1'b1;
        deliveredMessage    <= message;
      end
      if (setDesched) shouldDescheduleSender <= 1'b1;
      if (setError)   protocolError          <= 1'b1;
    end
  end

endmodule
